onehot_event_encoder: RTL and testbench
=======================================

# onehot_event_encoder

Captures single-cycle event pulses on an `NrOfBits`-wide bus (typically the one-hot/multi-hot change vector produced by XOR comparison of old and new GPIO/status words) into a sticky pending register. It then drains them as binary indices over a valid/ready handshake, lowest index first. It sits in the MCU peripheral path between the change-detect logic and the interrupt/event consumer, and performs the encode-and-serialize step that turns one-hot event vectors back into indices.

## Interface
- `NrOfBits`, default 8: number of event lines; legal range 2..32.
- `IndexBits`, default 3: width of `Index`; must be ≥ ceil(log2(`NrOfBits`)).
- `Clock` input 1: single clock; all state updates on the rising edge.
- `Reset_n` input 1: reset is synchronous and active-low.
- `Event_In` input `NrOfBits`: event pulses, sampled every edge; each set bit sets the matching pending bit.
- `Mask` input `NrOfBits`: 1 = bit eligible for presentation. Masked bits still capture; they are just not selected.
- `Clear_All` input 1: synchronous flush of pending, output and overflow.
- `Index_Ready` input 1: consumer accepts the presented index.
- `Index_Valid` output 1: `Index` holds a valid event number.
- `Index` output `IndexBits`: binary number of the presented event.
- `Pending` output `NrOfBits`: current pending register, including the presented bit.
- `Overflow` output 1: sticky flag; an event was lost because it hit an already-pending bit.

## Operation
- Pending register update, per bit i, evaluated each edge:
  - `Clear_All`: bit → 0.
  - Otherwise, `Event_In[i]`: bit → 1.
  - Otherwise, accept of index i (`Index_Valid & Index_Ready & Index==i`): bit → 0.
  - Otherwise: bit holds.
- Event and accept on the same bit in the same cycle: bit stays 1; this is not an overflow.
- Overflow: set when `Event_In[i]`=1, `Pending[i]`=1, and bit i is not being accepted that cycle. It is sticky and cleared only by `Clear_All` or reset.
- Output register has two states:
  - EMPTY: `Index_Valid`=0.
  - PRESENT: `Index_Valid`=1.
- Output is "free" at an edge when state is EMPTY, or when state is PRESENT and `Index_Ready`=1.
- When free: candidate vector = `Pending & Mask & ~accepted_bit`, using pending as it was *before* this edge. `Event_In` arriving in the same cycle is not a candidate.
  - Candidate nonzero: go to PRESENT; `Index` loads the lowest set bit position.
  - Candidate zero: go to EMPTY.
- PRESENT with `Index_Ready`=0: `Index` and `Index_Valid` hold stable. Masking the presented bit after presentation does not retract it.
- `Clear_All`: next state EMPTY, `Index`=0, pending=0, Overflow=0. `Clear_All` overrides same-cycle `Event_In` and accept.
- `Index` upper bits beyond log2(`NrOfBits`) are always 0. When EMPTY, `Index` is driven 0.

## Timing
- Reset (`Reset_n`=0 at an edge): `Pending`=0, `Index_Valid`=0, `Index`=0, `Overflow`=0. This applies mid-handshake; an in-flight index is dropped without an accept.
- Event latency: an event sampled at edge E is visible in `Pending` after E. With the output idle, `Index_Valid`=1 with its index after edge E+1 (2 cycles from pulse).
- Back-to-back drain: with `Index_Ready` held 1, one index is accepted per cycle with no bubble while candidates exist.
- The last accept with no remaining candidates gives `Index_Valid`=0 the next cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset then `Event_In`=0x00 for 5 cycles → `Index_Valid`=0, `Pending`=0x00, `Overflow`=0 throughout.
- Single pulse `Event_In`=0x24 at edge 1, `Index_Ready`=1, `Mask`=0xFF:
  - `Pending`=0x24 after edge 1.
  - `Index`=2 valid after edge 2, then `Index`=5 after edge 3.
  - `Index_Valid`=0 after edge 4; `Pending`=0x00.
- Backpressure: `Index_Ready`=0 for 4 cycles after `Index`=2 appears → `Index` stays 2 and `Index_Valid` stays 1. Raise `Index_Ready` → 2 is accepted, then 5.
- Mask: `Event_In`=0x81, `Mask`=0x80 → only `Index`=7 is presented; `Pending` stays 0x01. Set `Mask`=0xFF → `Index`=0 is presented 1 cycle later.
- Overflow and collision cases:
  - Pulse bit 3 twice while pending and not accepted → `Overflow`=1.
  - Pulse bit 3 in the same cycle it is accepted → `Pending[3]`=1, `Overflow` unchanged, and 3 is re-presented.
- `Clear_All`, then `Reset_n`, each mid-handshake with `Event_In`=0x10 in the same cycle → all outputs 0 next cycle and `Pending`=0x00.

Source files
------------

// File: rtl/onehot_event_encoder.sv
// Sticky event capture that serializes pending events as binary indices,
// lowest index first, over a valid/ready handshake.
module onehot_event_encoder #(
  parameter int NrOfBits  = 8,
  parameter int IndexBits = 3
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [NrOfBits-1:0]  Event_In,
  input  logic [NrOfBits-1:0]  Mask,
  input  logic                 Clear_All,
  input  logic                 Index_Ready,
  output logic                 Index_Valid,
  output logic [IndexBits-1:0] Index,
  output logic [NrOfBits-1:0]  Pending,
  output logic                 Overflow
);

  typedef enum logic {
    EMPTY   = 1'b0,
    PRESENT = 1'b1
  } state_e;

  state_e                 state_q;
  logic [IndexBits-1:0]   index_q;
  logic [NrOfBits-1:0]    pending_q, pending_d;
  logic                   overflow_q, overflow_d;

  logic                   accept;
  logic                   out_free;
  logic [NrOfBits-1:0]    accepted_vec;
  logic [NrOfBits-1:0]    candidates;
  logic [IndexBits-1:0]   lowest_idx;

  assign accept   = (state_q == PRESENT) && Index_Ready;
  assign out_free = (state_q == EMPTY) || Index_Ready;

  // NOTE: combinational logic uses blocking assignments with a default first,
  // so every path assigns every output and no latch is inferred.
  always_comb begin
    accepted_vec = '0;
    for (int i = 0; i < NrOfBits; i++) begin
      accepted_vec[i] = accept && (index_q == IndexBits'(i));
    end
  end

  // Candidates come from pending as it stood before this edge, so a
  // same-cycle event is never presented in the cycle it arrives.
  assign candidates = pending_q & Mask & ~accepted_vec;

  always_comb begin
    lowest_idx = '0;
    for (int i = NrOfBits - 1; i >= 0; i--) begin
      if (candidates[i]) lowest_idx = IndexBits'(i);
    end
  end

  // An event on a bit being accepted this cycle re-arms it without overflow.
  always_comb begin
    pending_d  = (pending_q & ~accepted_vec) | Event_In;
    overflow_d = overflow_q | (|(Event_In & pending_q & ~accepted_vec));
    if (Clear_All) begin
      pending_d  = '0;
      overflow_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q    <= EMPTY;
      index_q    <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      if (Clear_All) begin
        state_q <= EMPTY;
        index_q <= '0;
      end else if (out_free) begin
        if (|candidates) begin
          state_q <= PRESENT;
          index_q <= lowest_idx;
        end else begin
          state_q <= EMPTY;
          index_q <= '0;
        end
      end
    end
  end

  assign Index_Valid = (state_q == PRESENT);
  assign Index       = index_q;
  assign Pending     = pending_q;
  assign Overflow    = overflow_q;

endmodule

// File: tb/tb_onehot_event_encoder.sv
// Directed bench for onehot_event_encoder: capture, ordered drain, backpressure,
// masking, overflow/collision, and mid-handshake clear and reset.
module tb_onehot_event_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] event_in;
  logic [7:0] mask;
  logic       clear_all;
  logic       index_ready;
  logic       index_valid;
  logic [2:0] index;
  logic [7:0] pending;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  onehot_event_encoder #(
    .NrOfBits  (8),
    .IndexBits (3)
  ) dut (
    .Clock       (clk),
    .Reset_n     (rst_n),
    .Event_In    (event_in),
    .Mask        (mask),
    .Clear_All   (clear_all),
    .Index_Ready (index_ready),
    .Index_Valid (index_valid),
    .Index       (index),
    .Pending     (pending),
    .Overflow    (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [2:0] idx,
                           input logic [7:0] pend, input logic ovf);
    check({tag, ".valid"},    32'(index_valid), 32'(v));
    check({tag, ".index"},    32'(index),       32'(idx));
    check({tag, ".pending"},  32'(pending),     32'(pend));
    check({tag, ".overflow"}, 32'(overflow),    32'(ovf));
  endtask

  initial begin
    rst_n       = 1'b0;
    event_in    = 8'h00;
    mask        = 8'hFF;
    clear_all   = 1'b0;
    index_ready = 1'b0;
    tick();
    tick();
    check_all("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("idle", 1'b0, 3'd0, 8'h00, 1'b0);
    end

    // Single pulse, drained back to back.
    index_ready = 1'b1;
    event_in    = 8'h24;
    tick();
    check_all("pulse.e1", 1'b0, 3'd0, 8'h24, 1'b0);
    event_in = 8'h00;
    tick();
    check_all("pulse.e2", 1'b1, 3'd2, 8'h24, 1'b0);
    tick();
    check_all("pulse.e3", 1'b1, 3'd5, 8'h20, 1'b0);
    tick();
    check_all("pulse.e4", 1'b0, 3'd0, 8'h00, 1'b0);

    // Backpressure holds the presented index.
    index_ready = 1'b0;
    event_in    = 8'h24;
    tick();
    event_in = 8'h00;
    tick();
    check_all("bp.present", 1'b1, 3'd2, 8'h24, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("bp.hold", 1'b1, 3'd2, 8'h24, 1'b0);
    end
    index_ready = 1'b1;
    tick();
    check_all("bp.acc2", 1'b1, 3'd5, 8'h20, 1'b0);
    tick();
    check_all("bp.acc5", 1'b0, 3'd0, 8'h00, 1'b0);

    // Masked bit stays pending until unmasked.
    mask     = 8'h80;
    event_in = 8'h81;
    tick();
    check_all("mask.cap", 1'b0, 3'd0, 8'h81, 1'b0);
    event_in = 8'h00;
    tick();
    check_all("mask.p7", 1'b1, 3'd7, 8'h81, 1'b0);
    tick();
    check_all("mask.held", 1'b0, 3'd0, 8'h01, 1'b0);
    mask = 8'hFF;
    tick();
    check_all("mask.p0", 1'b1, 3'd0, 8'h01, 1'b0);
    tick();
    check_all("mask.done", 1'b0, 3'd0, 8'h00, 1'b0);

    // Overflow: second pulse on a pending, unaccepted bit.
    index_ready = 1'b0;
    event_in    = 8'h08;
    tick();
    check_all("ovf.first", 1'b0, 3'd0, 8'h08, 1'b0);
    tick();
    check_all("ovf.second", 1'b1, 3'd3, 8'h08, 1'b1);
    event_in  = 8'h00;
    clear_all = 1'b1;
    tick();
    check_all("ovf.clear", 1'b0, 3'd0, 8'h00, 1'b0);
    clear_all = 1'b0;

    // Collision: event on the bit being accepted re-arms it without overflow.
    event_in = 8'h08;
    tick();
    event_in = 8'h00;
    tick();
    check_all("coll.present", 1'b1, 3'd3, 8'h08, 1'b0);
    index_ready = 1'b1;
    event_in    = 8'h08;
    tick();
    check_all("coll.accept", 1'b0, 3'd0, 8'h08, 1'b0);
    event_in = 8'h00;
    tick();
    check_all("coll.repres", 1'b1, 3'd3, 8'h08, 1'b0);
    tick();
    check_all("coll.done", 1'b0, 3'd0, 8'h00, 1'b0);

    // Clear_All mid-handshake overrides a same-cycle event.
    index_ready = 1'b0;
    event_in    = 8'h02;
    tick();
    tick();
    check_all("clr.setup", 1'b1, 3'd1, 8'h02, 1'b1);
    event_in  = 8'h10;
    clear_all = 1'b1;
    tick();
    check_all("clr.flush", 1'b0, 3'd0, 8'h00, 1'b0);
    clear_all = 1'b0;
    event_in  = 8'h00;

    // Reset mid-handshake drops the in-flight index and the same-cycle event.
    event_in = 8'h02;
    tick();
    tick();
    check_all("rst.setup", 1'b1, 3'd1, 8'h02, 1'b1);
    event_in = 8'h10;
    rst_n    = 1'b0;
    tick();
    check_all("rst.flush", 1'b0, 3'd0, 8'h00, 1'b0);
    rst_n    = 1'b1;
    event_in = 8'h00;
    tick();
    check_all("rst.after", 1'b0, 3'd0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
